fifo_rd_stream: RTL and testbench

- Read-side consumer of the dual-clock FIFO. Lives entirely in the FIFO read domain.
- Drives the FIFO's rinc, samples its registered rdata one cycle later, and presents words on a valid/ready stream interface.
- Hides the FIFO's 1-cycle read latency and the empty flag from downstream logic.
- A 2-entry output buffer sustains 1 word/cycle under continuous m_ready.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_rd_skid2.sv | 39 +++
 rtl/fifo_rd_stream.sv | 71 +++++++
 tb/tb_fifo_rd_stream.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the dual-clock FIFO and its read-side stream adapter.
package fifo_pkg;

    localparam int DSIZE_DEFAULT = 8;
    localparam int ASIZE_DEFAULT = 4;

    typedef logic [DSIZE_DEFAULT-1:0] data_t;

    // Occupancy of the 2-entry output buffer (0..2)
    typedef logic [1:0] cnt_t;
    localparam cnt_t SKID_DEPTH = 2'd2;

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry FIFO buffer absorbing the FIFO read latency; head is forced to 0 while empty.
module fifo_rd_skid2
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             rd_en,
    output cnt_t             count,
    output logic [DSIZE-1:0] head
);

    logic [DSIZE-1:0] mem_p1 [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (rd_en) rd_ptr <= ~rd_ptr;
            count <= count + cnt_t'(wr_en) - cnt_t'(rd_en);
        end
    end

    // Storage carries data only; occupancy lives in count
    always_ff @(posedge clk) begin
        if (wr_en) mem_p1[wr_ptr] <= wr_data;
    end

    assign head = (count != '0) ? mem_p1[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-domain consumer: pops the FIFO, hides its 1-cycle latency, emits a valid/ready stream.
// Optional FIFO_RD_STREAM_STATS_EN adds saturating word_cnt / stall_cnt outputs.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [15:0]      word_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    cnt_t             count;
    logic             inflight_p1;
    logic             pop_out;
    logic [2:0]       occ_next;
    logic [DSIZE-1:0] head_data;

    assign pop_out  = m_valid && m_ready;
    // Occupancy after this edge, before counting a new pop; buffer plus the word in flight
    assign occ_next = {1'b0, count} + {2'b00, inflight_p1} - {2'b00, pop_out};
    assign rinc     = rrst_n && !rempty && (occ_next < {1'b0, SKID_DEPTH});

    // Stage p1: the FIFO presents rdata one cycle after the pop
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) inflight_p1 <= 1'b0;
        else         inflight_p1 <= rinc;
    end

    fifo_rd_skid2 #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .wr_en   (inflight_p1),
        .wr_data (rdata),
        .rd_en   (pop_out),
        .count   (count),
        .head    (head_data)
    );

    assign m_valid = (count != '0);
    assign m_data  = head_data;

`ifdef FIFO_RD_STREAM_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            word_cnt  <= sat_inc16(word_cnt, pop_out);
            stall_cnt <= sat_inc16(stall_cnt, m_valid && !m_ready);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: queue-based FIFO model upstream, in-order checker downstream.
module tb_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] word_cnt;
    logic [15:0] stall_cnt;
`endif

    fifo_rd_stream #(.DSIZE(8)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int cyc = 0;
    int beats = 0;
    int pops_issued = 0;
    int rinc_pulses = 0;
    int occ;
    int first_valid_cyc = -1;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    logic last_rinc = 1'b0;
    logic last_mvalid = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int exp_words = 0;
    int exp_stalls = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream monitor: in-order scoreboard, stability under backpressure, occupancy bound
    always @(negedge rclk) begin
        cyc++;
        if (!rrst_n) begin
            prev_stall = 1'b0;
        end else begin
            occ = pops_issued - beats;
            check("occupancy_le2", int'(occ <= 2), 1);
            if (first_valid_cyc < 0 && m_valid) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data), int'(prev_data));
            end
`ifdef FIFO_RD_STREAM_STATS_EN
            check("word_cnt", int'(word_cnt), exp_words);
            check("stall_cnt", int'(stall_cnt), exp_stalls);
            if (m_valid && m_ready && exp_words < 65535) exp_words++;
            if (m_valid && !m_ready && exp_stalls < 65535) exp_stalls++;
`endif
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected no word", m_data);
                end else begin
                    check("data_order", int'(m_data), int'(exp_q.pop_front()));
                end
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // One clock cycle: sample at negedge, then model the FIFO's registered read after the edge
    task automatic step();
        @(negedge rclk);
        last_rinc   = rinc;
        last_mvalid = m_valid;
        if (rinc) begin
            check("rinc_while_empty", int'(rempty), 0);
            rinc_pulses++;
        end
        @(posedge rclk);
        #1;
        if (last_rinc) begin
            if (fifo_q.size() > 0) rdata = fifo_q.pop_front();
            pops_issued++;
        end
        rempty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        rempty = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !m_valid) break;
            step();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        #1;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_rinc", int'(rinc), 0);
        check("rst_m_data", int'(m_data), 0);
        fifo_q.delete();
        exp_q.delete();
        rempty      = 1'b1;
        pops_issued = 0;
        beats       = 0;
        exp_words   = 0;
        exp_stalls  = 0;
        repeat (3) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    task automatic latency_test();
        int c0;
        m_ready = 1'b1;
        first_valid_cyc = -1;
        first_beat_cyc  = -1;
        last_beat_cyc   = -1;
        for (int w = 0; w < 8; w++) push(8'h11 + 8'(w));
        c0 = cyc;
        step();
        check("rinc_cycle0", int'(last_rinc), 1);
        repeat (13) step();
        check("first_valid_cycle2", first_valid_cyc, c0 + 3);
        check("first_beat_cycle2", first_beat_cyc, c0 + 3);
        check("beats_no_gaps", last_beat_cyc - first_beat_cyc, 7);
        check("latency_all_delivered", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        m_ready = 1'b0;
        rdata   = 8'h00;
        #2;
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_rinc", int'(rinc), 0);
        check("reset_m_data", int'(m_data), 0);
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;

        // Idle: FIFO empty for 20 cycles
        for (int i = 0; i < 20; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
            check("idle_rinc", int'(last_rinc), 0);
            check("idle_m_valid", int'(last_mvalid), 0);
        end

        latency_test();

        // Backpressure: exactly two pops while stalled, head held
        m_ready     = 1'b0;
        rinc_pulses = 0;
        for (int w = 0; w < 8; w++) push(8'h11 + 8'(w));
        repeat (10) step();
        check("stall_rinc_pulses", rinc_pulses, 2);
        check("stall_m_valid", int'(m_valid), 1);
        check("stall_m_data", int'(m_data), 8'h11);
        m_ready = 1'b1;
        drain(40);

        // Toggling ready while the FIFO streams 16 words
        for (int i = 0; i < 16; i++) begin
            push(8'($urandom));
            m_ready = (i % 2 == 0);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        m_ready = 1'b1;
        drain(20);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 60) push(8'($urandom));
            m_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        m_ready = 1'b1;
        drain(3000);

        // Reset with one word buffered and one in flight
        m_ready = 1'b0;
        for (int w = 0; w < 8; w++) push(8'hA0 + 8'(w));
        step();
        step();
        check("pre_reset_m_valid", int'(m_valid), 1);
        do_reset();
        repeat (3) step();
        check("post_reset_idle_valid", int'(m_valid), 0);
        latency_test();
        drain(20);

`ifdef FIFO_RD_STREAM_STATS_EN
        do_reset();
        m_ready = 1'b0;
        for (int w = 0; w < 5; w++) push(8'h50 + 8'(w));
        repeat (5) step();
        m_ready = 1'b1;
        drain(20);
        check("stats_word_cnt5", int'(word_cnt), 5);
        check("stats_stall_cnt3", int'(stall_cnt), 3);

        for (int i = 0; i < 70000; i++) begin
            push(8'(i));
            step();
        end
        drain(20);
        check("stats_word_sat", int'(word_cnt), 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
